// File: rtl/me_best_mv_collector_pkg.sv
// Shared widths, FSM state type and CB index constants for the best-MV collector.
// The record widths here match the PE array controller's search counters.
package me_best_mv_collector_pkg;

  localparam int SAD_W_DEF = 16;
  localparam int COL_W_DEF = 5;
  localparam int ROW_W_DEF = 7;
  localparam int NUM_CB    = 4;
  localparam int CB_W      = 2;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DRAIN
  } state_e;

  localparam logic [CB_W-1:0] CB0 = 2'd0;
  localparam logic [CB_W-1:0] CB1 = 2'd1;
  localparam logic [CB_W-1:0] CB2 = 2'd2;
  localparam logic [CB_W-1:0] CB3 = 2'd3;

  localparam logic [SAD_W_DEF-1:0] SAD_INIT = '1;

endpackage

// File: rtl/me_best_mv_collector_sad_min_reg.sv
// Running minimum of SAD for one sub-block, with the position where it occurred.
// The comparison is strict, so on a tie the earlier sample's position is kept.
module me_best_mv_collector_sad_min_reg #(
  parameter int SAD_W = 16,
  parameter int COL_W = 5,
  parameter int ROW_W = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             upd_i,
  input  logic [SAD_W-1:0] sad_i,
  input  logic [COL_W-1:0] col_i,
  input  logic [ROW_W-1:0] row_i,
  output logic [SAD_W-1:0] sad_o,
  output logic [COL_W-1:0] col_o,
  output logic [ROW_W-1:0] row_o,
  output logic             hit_o
);

  logic [SAD_W-1:0] sad_q, sad_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             hit_q, hit_d;

  always_comb begin
    sad_d = sad_q;
    col_d = col_q;
    row_d = row_q;
    hit_d = hit_q;
    if (clear_i) begin
      sad_d = '1;
      col_d = '0;
      row_d = '0;
      hit_d = 1'b0;
    end else if (upd_i) begin
      hit_d = 1'b1;
      if (sad_i < sad_q) begin
        sad_d = sad_i;
        col_d = col_i;
        row_d = row_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sad_q <= '1;
      col_q <= '0;
      row_q <= '0;
      hit_q <= 1'b0;
    end else begin
      sad_q <= sad_d;
      col_q <= col_d;
      row_q <= row_d;
      hit_q <= hit_d;
    end
  end

  assign sad_o = sad_q;
  assign col_o = col_q;
  assign row_o = row_q;
  assign hit_o = hit_q;

endmodule

// File: rtl/me_best_mv_collector.sv
// Collects per-CB minimum SAD during a search and drains the four best records
// in CB order over a valid/ready port once the search window is complete.
module me_best_mv_collector
  import me_best_mv_collector_pkg::*;
#(
  parameter int SAD_W = SAD_W_DEF,
  parameter int COL_W = COL_W_DEF,
  parameter int ROW_W = ROW_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             sad_valid_i,
  input  logic [1:0]       sad_cb_i,
  input  logic [COL_W-1:0] sad_col_i,
  input  logic [ROW_W-1:0] sad_row_i,
  input  logic [SAD_W-1:0] sad_val_i,
  input  logic             search_done_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [1:0]       res_cb_o,
  output logic [SAD_W-1:0] res_sad_o,
  output logic [COL_W-1:0] res_col_o,
  output logic [ROW_W-1:0] res_row_o,
  output logic             res_hit_o,
  output logic             busy_o,
  output logic             done_o
);

  state_e          state_q, state_d;
  logic [CB_W-1:0] idx_q, idx_d;
  logic            valid_q, valid_d;
  logic            busy_q;
  logic            done_q, done_d;
  logic            clear;

  logic [SAD_W-1:0] recSad [NUM_CB];
  logic [COL_W-1:0] recCol [NUM_CB];
  logic [ROW_W-1:0] recRow [NUM_CB];
  logic             recHit [NUM_CB];

  for (genvar g = 0; g < NUM_CB; g++) begin : gen_cb
    logic upd;
    assign upd = (state_q == COLLECT) && sad_valid_i && !start_i &&
                 (sad_cb_i == CB_W'(g));

    me_best_mv_collector_sad_min_reg #(
      .SAD_W(SAD_W),
      .COL_W(COL_W),
      .ROW_W(ROW_W)
    ) u_min (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear_i(clear),
      .upd_i  (upd),
      .sad_i  (sad_val_i),
      .col_i  (sad_col_i),
      .row_i  (sad_row_i),
      .sad_o  (recSad[g]),
      .col_o  (recCol[g]),
      .row_o  (recRow[g]),
      .hit_o  (recHit[g])
    );
  end

  // start overrides everything, including a drain in progress and a same-cycle search_done
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    clear   = 1'b0;
    if (start_i) begin
      clear   = 1'b1;
      state_d = COLLECT;
      idx_d   = CB0;
      valid_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: ;
        COLLECT: begin
          if (search_done_i) begin
            state_d = DRAIN;
            idx_d   = CB0;
            valid_d = 1'b1;
          end
        end
        DRAIN: begin
          if (valid_q && res_ready_i) begin
            if (idx_q == CB3) begin
              valid_d = 1'b0;
              done_d  = 1'b1;
              state_d = IDLE;
            end else begin
              idx_d = idx_q + 2'd1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= CB0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      busy_q  <= (state_d != IDLE);
      done_q  <= done_d;
    end
  end

  // Records are frozen during DRAIN, so reading them through the mux keeps the output stable
  always_comb begin
    res_cb_o  = '0;
    res_sad_o = '0;
    res_col_o = '0;
    res_row_o = '0;
    res_hit_o = 1'b0;
    if (valid_q) begin
      res_cb_o  = idx_q;
      res_sad_o = recSad[idx_q];
      res_col_o = recCol[idx_q];
      res_row_o = recRow[idx_q];
      res_hit_o = recHit[idx_q];
    end
  end

  assign res_valid_o = valid_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_me_best_mv_collector.sv
// Scoreboard bench: a sample-list reference model predicts the four drained records,
// and a negedge monitor checks every presented record and the done pulse.
module tb_me_best_mv_collector;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        sadValid = 1'b0;
  logic [1:0]  sadCb = '0;
  logic [4:0]  sadCol = '0;
  logic [6:0]  sadRow = '0;
  logic [15:0] sadVal = '0;
  logic        searchDone = 1'b0;
  logic        resValid;
  logic        resReady = 1'b0;
  logic [1:0]  resCb;
  logic [15:0] resSad;
  logic [4:0]  resCol;
  logic [6:0]  resRow;
  logic        resHit;
  logic        busy;
  logic        done;

  typedef struct {
    logic [1:0]  cb;
    logic [15:0] sad;
    logic [4:0]  col;
    logic [6:0]  row;
    logic        hit;
  } rec_t;

  rec_t samples[$];
  rec_t expQ[$];
  int   checks = 0;
  int   failures = 0;
  int   hsCount = 0;
  bit   doneDue = 0;
  bit   collecting = 0;

  me_best_mv_collector dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start),
    .sad_valid_i  (sadValid),
    .sad_cb_i     (sadCb),
    .sad_col_i    (sadCol),
    .sad_row_i    (sadRow),
    .sad_val_i    (sadVal),
    .search_done_i(searchDone),
    .res_valid_o  (resValid),
    .res_ready_i  (resReady),
    .res_cb_o     (resCb),
    .res_sad_o    (resSad),
    .res_col_o    (resCol),
    .res_row_o    (resRow),
    .res_hit_o    (resHit),
    .busy_o       (busy),
    .done_o       (done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  // Monitor: every presented record must equal the scoreboard head; pop on handshake
  always @(negedge clk) begin
    if (!rst_n) begin
      doneDue = 0;
    end else begin
      checks++;
      if (done !== doneDue) begin
        failures++;
        $display("[TB] FAIL done_pulse got=%0b exp=%0b t=%0t", done, doneDue, $time);
      end
      doneDue = 0;
      if (resValid) begin
        checks++;
        if (expQ.size() == 0) begin
          failures++;
          $display("[TB] FAIL unexpected_valid got cb=%0d sad=%h t=%0t", resCb, resSad, $time);
        end else begin
          if ({resCb, resSad, resCol, resRow, resHit} !==
              {expQ[0].cb, expQ[0].sad, expQ[0].col, expQ[0].row, expQ[0].hit}) begin
            failures++;
            $display("[TB] FAIL record got cb=%0d sad=%h col=%0d row=%0d hit=%0b exp cb=%0d sad=%h col=%0d row=%0d hit=%0b t=%0t",
                     resCb, resSad, resCol, resRow, resHit,
                     expQ[0].cb, expQ[0].sad, expQ[0].col, expQ[0].row, expQ[0].hit, $time);
          end
          if (resReady) begin
            if (expQ[0].cb == 2'd3) doneDue = 1;
            void'(expQ.pop_front());
            hsCount++;
          end
        end
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkFlag(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic checkOutput(input string name);
    checkFlag(name, {resValid, resCb, resSad, resCol, resRow, resHit, busy, done}, 32'd0);
  endtask

  // Reference: for each CB, the lowest SAD wins; the first occurrence wins ties
  task automatic pushExpected();
    for (int c = 0; c < 4; c++) begin
      rec_t r;
      r.cb = 2'(c); r.sad = 16'hFFFF; r.col = '0; r.row = '0; r.hit = 0;
      foreach (samples[i]) begin
        if (samples[i].cb == 2'(c)) begin
          r.hit = 1;
          if (samples[i].sad < r.sad) begin
            r.sad = samples[i].sad; r.col = samples[i].col; r.row = samples[i].row;
          end
        end
      end
      expQ.push_back(r);
    end
  endtask

  task automatic doStart();
    start = 1;
    sadValid = 1; sadCb = 2'd0; sadVal = 16'd0; sadCol = 5'd31; sadRow = 7'd99;
    searchDone = 1;
    cycle();
    start = 0; sadValid = 0; searchDone = 0;
    samples.delete();
    expQ.delete();
    collecting = 1;
  endtask

  task automatic applyStimulus(input bit v, input logic [1:0] cb, input logic [4:0] col,
                               input logic [6:0] row, input logic [15:0] sad, input bit sd);
    rec_t s;
    sadValid = v; sadCb = cb; sadCol = col; sadRow = row; sadVal = sad; searchDone = sd;
    cycle();
    sadValid = 0; searchDone = 0;
    if (collecting && v) begin
      s.cb = cb; s.sad = sad; s.col = col; s.row = row; s.hit = 1;
      samples.push_back(s);
    end
    if (collecting && sd) begin
      pushExpected();
      collecting = 0;
    end
  endtask

  task automatic drainAll(input bit randomReady);
    for (int i = 0; i < 300 && expQ.size() != 0; i++) begin
      resReady = randomReady ? 1'($urandom_range(0, 1)) : 1'b1;
      cycle();
    end
    resReady = 0;
    checks++;
    if (expQ.size() != 0) begin
      failures++;
      $display("[TB] FAIL drain_timeout got=%0d left exp=0", expQ.size());
      expQ.delete();
    end
    cycle();
    checkFlag("busy_after_drain", busy, 0);
  endtask

  task automatic randomSearch(input int n, input bit narrow);
    for (int i = 0; i < n; i++) begin
      applyStimulus(($urandom_range(0, 4) != 0), 2'($urandom_range(0, 3)),
                    5'($urandom), 7'($urandom),
                    narrow ? 16'($urandom_range(0, 7)) : 16'($urandom), 0);
    end
    applyStimulus($urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)), 5'($urandom),
                  7'($urandom), 16'($urandom), 1);
  endtask

  initial begin
    int h0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_outputs");
    rst_n = 1;
    cycle();
    checkOutput("idle_after_reset");

    // T2 single CB
    doStart();
    checkFlag("busy_collect", busy, 1);
    applyStimulus(1, 2'd0, 5'd1, 7'd3, 16'd500, 0);
    applyStimulus(1, 2'd0, 5'd4, 7'd10, 16'd120, 0);
    applyStimulus(1, 2'd0, 5'd5, 7'd2, 16'd300, 0);
    applyStimulus(0, 2'd0, 5'd0, 7'd0, 16'd0, 1);
    drainAll(0);

    // T3 tie, and T5 sample on the search_done cycle
    doStart();
    applyStimulus(1, 2'd2, 5'd2, 7'd5, 16'd77, 0);
    applyStimulus(1, 2'd2, 5'd9, 7'd40, 16'd77, 0);
    applyStimulus(1, 2'd3, 5'd7, 7'd7, 16'd900, 0);
    applyStimulus(1, 2'd3, 5'd6, 7'd8, 16'd1, 1);
    drainAll(1);

    // T4 backpressure on CB1, then back-to-back acceptance
    doStart();
    randomSearch(12, 0);
    resReady = 1;
    cycle();
    resReady = 0;
    repeat (5) cycle();
    h0 = hsCount;
    resReady = 1;
    repeat (3) cycle();
    resReady = 0;
    checkFlag("bp_consecutive", hsCount - h0, 3);
    checkFlag("bp_done", done, 1);
    checkFlag("bp_busy", busy, 0);
    cycle();

    // Stray inputs while idle are ignored
    applyStimulus(1, 2'd1, 5'd3, 7'd3, 16'd5, 1);
    repeat (3) cycle();
    checkOutput("idle_ignores_inputs");

    // T6 restart after CB0 accepted
    doStart();
    randomSearch(10, 1);
    resReady = 1;
    cycle();
    resReady = 0;
    doStart();
    checkFlag("restart_valid", resValid, 0);
    checkFlag("restart_busy", busy, 1);
    randomSearch(8, 1);
    drainAll(1);

    // T1 asynchronous reset in the middle of a drain
    doStart();
    randomSearch(6, 0);
    repeat (2) cycle();
    #2 rst_n = 0;
    #1 checkOutput("async_reset_mid_drain");
    expQ.delete();
    collecting = 0;
    @(posedge clk);
    #1 rst_n = 1;
    cycle();
    checkOutput("after_async_reset");

    // Randomised searches
    for (int r = 0; r < 10; r++) begin
      doStart();
      randomSearch($urandom_range(0, 30), r[0]);
      drainAll(1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
